// File: rtl/rei_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rei_pkg
// Description : Shared types and constants for the data-bus arbiter slice.
//               XLEN / XBYTES  : data/address width and strobe width
//               arb_mode_e     : arbitration policy selector
//               NUM_DBUS_MGR   : managers sharing the data bus
//               dbus_req_s     : one manager's request bundle
// Revision    : 1.0 - initial release
// ============================================================================
package rei_pkg;

  localparam int XLEN         = 64;
  localparam int XBYTES       = XLEN / 8;
  localparam int NUM_DBUS_MGR = 2;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  typedef struct packed {
    logic              arvalid;
    logic              wvalid;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [XBYTES-1:0] wstrb;
  } dbus_req_s;

endpackage : rei_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way combinational grant with a round-robin pointer.
// Ports       : clk_i, rst_i  - clock, synchronous active-high reset
//               req0, req1    - request from manager 0 / 1
//               ready         - downstream accepts this cycle
//               gnt           - index of the winning manager
//               rr_q          - round-robin pointer (preferred manager)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
  import rei_pkg::*;
#(
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req0,
  input  logic req1,
  input  logic ready,
  output logic gnt,
  output logic rr_q
);

  always_comb begin
    gnt = 1'b0;
    if (req0 && req1) begin
      gnt = (ARB_MODE == ARB_FIXED) ? 1'b0 : rr_q;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

  // Pointer only moves on a contended grant that is actually taken; it then
  // points at the loser so that manager wins the next contention.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= 1'b0;
    end else if (req0 && req1 && ready) begin
      rr_q <= ~gnt;
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dbus_arbiter
// Description : Shares one data-bus port between the LSU (manager 0) and a
//               secondary requester (manager 1). Grants one request per
//               cycle, stalls the loser, and steers the single outstanding
//               read response back to the manager that issued it.
// Ports       : clk_i, rst_i          - clock, synchronous active-high reset
//               mN_arvalid_i/wvalid_i - read / write request from manager N
//               mN_addr/wdata/wstrb_i - request payload from manager N
//               mN_stall_o            - request present but not accepted
//               mN_rvalid/rdata_o     - read response for manager N
//               s_ready_i             - memory accepts a request
//               s_*_o                 - forwarded request to memory
//               s_rdata_i             - read data, 1 cycle after acceptance
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_arbiter
  import rei_pkg::*;
#(
  parameter int        XLEN     = rei_pkg::XLEN,
  parameter int        XBYTES   = XLEN / 8,
  parameter arb_mode_e ARB_MODE = ARB_RR
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_arvalid_i,
  input  logic              m1_arvalid_i,
  input  logic              m0_wvalid_i,
  input  logic              m1_wvalid_i,
  input  logic [XLEN-1:0]   m0_addr_i,
  input  logic [XLEN-1:0]   m1_addr_i,
  input  logic [XLEN-1:0]   m0_wdata_i,
  input  logic [XLEN-1:0]   m1_wdata_i,
  input  logic [XBYTES-1:0] m0_wstrb_i,
  input  logic [XBYTES-1:0] m1_wstrb_i,
  output logic              m0_stall_o,
  output logic              m1_stall_o,
  output logic              m0_rvalid_o,
  output logic              m1_rvalid_o,
  output logic [XLEN-1:0]   m0_rdata_o,
  output logic [XLEN-1:0]   m1_rdata_o,
  input  logic              s_ready_i,
  output logic              s_arvalid_o,
  output logic              s_wvalid_o,
  output logic [XLEN-1:0]   s_addr_o,
  output logic [XLEN-1:0]   s_awaddr_o,
  output logic [XLEN-1:0]   s_araddr_o,
  output logic [XLEN-1:0]   s_wdata_o,
  output logic [XBYTES-1:0] s_wstrb_o,
  input  logic [XLEN-1:0]   s_rdata_i
);

  logic req0;
  logic req1;
  logic any_req;
  logic gnt;
  logic acc;
  logic rr_q;
  logic rd_pend_q;
  logic rd_owner_q;

  assign req0    = m0_arvalid_i | m0_wvalid_i;
  assign req1    = m1_arvalid_i | m1_wvalid_i;
  assign any_req = req0 | req1;
  assign acc     = any_req & s_ready_i;

  rr_arb2 #(
    .ARB_MODE (ARB_MODE)
  ) u_rr_arb2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req0  (req0),
    .req1  (req1),
    .ready (s_ready_i),
    .gnt   (gnt),
    .rr_q  (rr_q)
  );

  // Forward the winner; with no request every forwarded field is zero.
  always_comb begin
    s_arvalid_o = 1'b0;
    s_wvalid_o  = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    if (any_req) begin
      if (gnt) begin
        s_arvalid_o = m1_arvalid_i;
        s_wvalid_o  = m1_wvalid_i;
        s_addr_o    = m1_addr_i;
        s_wdata_o   = m1_wdata_i;
        s_wstrb_o   = m1_wstrb_i;
      end else begin
        s_arvalid_o = m0_arvalid_i;
        s_wvalid_o  = m0_wvalid_i;
        s_addr_o    = m0_addr_i;
        s_wdata_o   = m0_wdata_i;
        s_wstrb_o   = m0_wstrb_i;
      end
    end
  end

  assign s_awaddr_o = s_addr_o;
  assign s_araddr_o = s_addr_o;

  assign m0_stall_o = req0 & ~(acc & ~gnt);
  assign m1_stall_o = req1 & ~(acc &  gnt);

  // Single outstanding read: data returns exactly one cycle after
  // acceptance, so a one-cycle pending flag plus an owner bit is enough and
  // a new read can be accepted while the previous one returns.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q  <= acc & s_arvalid_o;
      rd_owner_q <= gnt;
    end
  end

  assign m0_rvalid_o = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid_o = rd_pend_q &  rd_owner_q;
  assign m0_rdata_o  = m0_rvalid_o ? s_rdata_i : '0;
  assign m1_rdata_o  = m1_rvalid_o ? s_rdata_i : '0;

endmodule : dbus_arbiter
`default_nettype wire
